// File: rtl/sw_loop_pkg.sv
`default_nettype none
// ============================================================================
// Module  : sw_loop_pkg
// Brief   : Shared PC encoding for the round-robin loop-step scheduler.
// Revision: 1.0
// ============================================================================
package sw_loop_pkg;

    localparam int L0_B = 0;
    localparam int L1_B = 1;
    localparam int L2_B = 2;
    localparam int L3_B = 3;
    localparam int L4_B = 4;
    localparam int L5_B = 5;
    localparam int L6_B = 6;
    localparam int PC_W = 7;

    typedef logic [PC_W-1:0] pc_t;

    localparam pc_t PC_L0    = pc_t'(1 << L0_B);
    localparam pc_t PC_L1    = pc_t'(1 << L1_B);
    localparam pc_t PC_L2    = pc_t'(1 << L2_B);
    localparam pc_t PC_L3    = pc_t'(1 << L3_B);
    localparam pc_t PC_L4    = pc_t'(1 << L4_B);
    localparam pc_t PC_L5    = pc_t'(1 << L5_B);
    localparam pc_t PC_L6    = pc_t'(1 << L6_B);
    localparam pc_t PC_RESET = PC_L0;

    function automatic logic pc_onehot(input pc_t pc);
        return (pc != '0) && ((pc & (pc - pc_t'(1))) == '0);
    endfunction

endpackage
`default_nettype wire

// File: rtl/sw_loop_step.sv
`default_nettype none
// ============================================================================
// Module  : sw_loop_step
// Brief   : Combinational single loop step: (pc, x) -> (pc_n, x_n).
// Revision: 1.0
// ============================================================================
module sw_loop_step
    import sw_loop_pkg::*;
#(
    parameter int           W     = 6,
    parameter logic [W-1:0] KINC  = W'(3),
    parameter logic [W-1:0] KCOND = W'(17),
    parameter logic [W-1:0] KPROP = W'(19)
) (
    input  pc_t          pc_i,
    input  logic [W-1:0] x_i,
    output pc_t          pc_o,
    output logic [W-1:0] x_o
);

    always_comb begin
        pc_o = pc_i;
        x_o  = x_i;
        if (pc_i[L0_B]) begin
            pc_o = PC_L1;
        end else if (pc_i[L1_B]) begin
            if (x_i < KPROP) begin
                x_o  = x_i + KINC;   // wraps mod 2^W
                pc_o = PC_L2;
            end else begin
                pc_o = PC_L6;
            end
        end else if (pc_i[L2_B]) begin
            pc_o = PC_L3;
        end else if (pc_i[L3_B]) begin
            pc_o = (x_i < KCOND) ? PC_L1 : PC_L4;
        end else if (pc_i[L4_B]) begin
            pc_o = (x_i < KPROP) ? PC_L5 : PC_L6;
        end
    end

endmodule
`default_nettype wire

// File: rtl/sw_loop_rr_sched.sv
`default_nettype none
// ============================================================================
// Module  : sw_loop_rr_sched
// Brief   : Round-robin scheduler time-sharing one loop-step datapath among
//           NTHR thread contexts, with restart load path and one-hot guard.
// Revision: 1.0
// ============================================================================
module sw_loop_rr_sched
    import sw_loop_pkg::*;
#(
    parameter int           NTHR  = 4,
    parameter int           W     = 6,
    parameter logic [W-1:0] KINIT = W'(1),
    parameter logic [W-1:0] KINC  = W'(3),
    parameter logic [W-1:0] KCOND = W'(17),
    parameter logic [W-1:0] KPROP = W'(19)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NTHR-1:0]         req_i,
    input  logic                    ld_i,
    input  logic [$clog2(NTHR)-1:0] ld_id_i,
    input  logic [W-1:0]            ld_x_i,
    output logic [NTHR-1:0]         gnt_o,
    output logic [NTHR*W-1:0]       x_flat_o,
    output logic [NTHR-1:0]         done_o,
    output logic [NTHR-1:0]         err_o,
    output logic                    ohfail_o,
    output logic                    busy_o
);

    localparam int IDW = $clog2(NTHR);

    pc_t  [NTHR-1:0]          pc_q, pc_d;
    logic [NTHR-1:0][W-1:0]   x_q,  x_d;
    logic [IDW-1:0]           ptr_q, ptr_d;
    logic                     ohfail_q, ohfail_d;

    logic [NTHR-1:0]          elig;
    logic [NTHR-1:0]          gnt;
    logic [IDW-1:0]           gnt_idx;
    logic [IDW-1:0]           cand;
    logic                     found;
    logic                     bad_any;
    pc_t                      step_pc;
    logic [W-1:0]             step_x;

    always_comb begin
        elig    = '0;
        bad_any = 1'b0;
        for (int i = 0; i < NTHR; i++) begin
            elig[i] = req_i[i] & ~pc_q[i][L5_B] & ~pc_q[i][L6_B]
                    & pc_onehot(pc_q[i])
                    & ~(ld_i & (ld_id_i == IDW'(i)));
            if (!pc_onehot(pc_q[i])) begin
                bad_any = 1'b1;
            end
        end
    end

    // Rotating search from ptr; NTHR is a power of two so the index wraps naturally.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        cand    = '0;
        found   = 1'b0;
        for (int o = 0; o < NTHR; o++) begin
            cand = ptr_q + IDW'(o);
            if (!found && elig[cand]) begin
                found   = 1'b1;
                gnt_idx = cand;
            end
        end
        gnt[gnt_idx] = found;
    end

    sw_loop_step #(
        .W     (W),
        .KINC  (KINC),
        .KCOND (KCOND),
        .KPROP (KPROP)
    ) u_step (
        .pc_i (pc_q[gnt_idx]),
        .x_i  (x_q[gnt_idx]),
        .pc_o (step_pc),
        .x_o  (step_x)
    );

    // Load is applied after the step so it wins; the grant mask already excludes it.
    always_comb begin
        pc_d     = pc_q;
        x_d      = x_q;
        ptr_d    = ptr_q;
        ohfail_d = ohfail_q | bad_any;
        if (found) begin
            pc_d[gnt_idx] = step_pc;
            x_d[gnt_idx]  = step_x;
            ptr_d         = gnt_idx + IDW'(1);
        end
        if (ld_i) begin
            pc_d[ld_id_i] = PC_RESET;
            x_d[ld_id_i]  = ld_x_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q     <= {NTHR{PC_RESET}};
            x_q      <= {NTHR{KINIT}};
            ptr_q    <= '0;
            ohfail_q <= 1'b0;
        end else begin
            pc_q     <= pc_d;
            x_q      <= x_d;
            ptr_q    <= ptr_d;
            ohfail_q <= ohfail_d;
        end
    end

    always_comb begin
        done_o = '0;
        err_o  = '0;
        for (int i = 0; i < NTHR; i++) begin
            done_o[i] = pc_q[i][L5_B];
            err_o[i]  = pc_q[i][L6_B];
        end
    end

    assign gnt_o    = gnt;
    assign busy_o   = found;
    assign x_flat_o = x_q;
    assign ohfail_o = ohfail_q;

    a_gnt_onehot0 : assert property (@(posedge clk) disable iff (rst) $onehot0(gnt_o));
    a_gnt_in_req  : assert property (@(posedge clk) disable iff (rst) (gnt_o & ~req_i) == '0);

endmodule
`default_nettype wire

// File: tb/tb_sw_loop_rr_sched.sv
`default_nettype none
// ============================================================================
// Module  : tb_sw_loop_rr_sched
// Brief   : Scoreboard bench for sw_loop_rr_sched with directed vectors.
// Revision: 1.0
// ============================================================================
module tb_sw_loop_rr_sched;

    localparam int NTHR = 4;
    localparam int W    = 6;

    logic              clk = 1'b0;
    logic              rst;
    logic [NTHR-1:0]   req;
    logic              ld;
    logic [1:0]        ld_id;
    logic [W-1:0]      ld_x;
    logic [NTHR-1:0]   gnt;
    logic [NTHR*W-1:0] x_flat;
    logic [NTHR-1:0]   done;
    logic [NTHR-1:0]   err;
    logic              ohfail;
    logic              busy;

    logic [NTHR-1:0]   exp_q[$];
    int                n_checks = 0;
    int                n_pass   = 0;

    sw_loop_rr_sched dut (
        .clk      (clk),
        .rst      (rst),
        .req_i    (req),
        .ld_i     (ld),
        .ld_id_i  (ld_id),
        .ld_x_i   (ld_x),
        .gnt_o    (gnt),
        .x_flat_o (x_flat),
        .done_o   (done),
        .err_o    (err),
        .ohfail_o (ohfail),
        .busy_o   (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act === expv) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, expv);
    endtask

    function automatic logic [31:0] xof(input int i);
        return 32'(x_flat[i*W +: W]);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_n(input logic [NTHR-1:0] g, input int n);
        for (int k = 0; k < n; k++) exp_q.push_back(g);
    endtask

    task automatic drain(input string name);
        check(name, 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    task automatic pulse_rst();
        rst = 1'b1;
        #1;
        rst = 1'b0;
    endtask

    // Monitor: every presented grant must match the next scoreboard entry.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst && busy) begin
                if (exp_q.size() == 0) check("unexpected_gnt", 32'(gnt), 32'd0);
                else                   check("gnt", 32'(gnt), 32'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        rst = 1'b1; req = '0; ld = 1'b0; ld_id = '0; ld_x = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_gnt",    32'(gnt),    32'd0);
        check("rst_done",   32'(done),   32'd0);
        check("rst_err",    32'(err),    32'd0);
        check("rst_ohfail", 32'(ohfail), 32'd0);
        check("rst_x",      32'(x_flat), 32'h041041);
        rst = 1'b0;

        // Load blocks the loaded thread's grant in that cycle.
        tick();
        req = 4'b0010; ld = 1'b1; ld_id = 2'd1; ld_x = 6'd5;
        tick();
        ld = 1'b0;
        push_n(4'b0010, 2);
        tick();
        tick();
        req = '0;
        check("ld_step_x1", xof(1), 32'd8);
        drain("ld_step_drain");

        // Another thread is still granted while thread 1 is loading.
        req = 4'b0011; ld = 1'b1; ld_id = 2'd1; ld_x = 6'd5;
        push_n(4'b0001, 1);
        tick();
        ld = 1'b0; req = '0;
        check("reload_x1", xof(1), 32'd5);
        check("other_x0",  xof(0), 32'd1);

        // Reset mid-run clears everything immediately.
        req = 4'b0001;
        push_n(4'b0001, 1);
        tick();
        req = '0;
        check("pre_rst_x0", xof(0), 32'd4);
        rst = 1'b1;
        #1;
        check("midrst_x",    32'(x_flat), 32'h041041);
        check("midrst_done", 32'(done),   32'd0);
        check("midrst_busy", 32'(busy),   32'd0);
        tick();
        rst = 1'b0;
        drain("midrst_drain");

        // Loop from X=0 ends done with X=18 after 20 grants.
        ld = 1'b1; ld_id = 2'd0; ld_x = 6'd0;
        tick();
        ld = 1'b0; req = 4'b0001;
        push_n(4'b0001, 20);
        repeat (25) tick();
        req = '0;
        check("t1_x0",   xof(0),     32'd18);
        check("t1_done", 32'(done),  32'h1);
        check("t1_err",  32'(err),   32'h0);
        drain("t1_drain");

        // Loop from KINIT=1 reaches X=19 and the bad state.
        pulse_rst();
        req = 4'b0001;
        push_n(4'b0001, 20);
        repeat (25) tick();
        req = '0;
        check("t2_x0",   xof(0),    32'd19);
        check("t2_err",  32'(err),  32'h1);
        check("t2_done", 32'(done), 32'h0);
        drain("t2_drain");

        // X=20 fails the guard immediately at L1.
        req = 4'b0100; ld = 1'b1; ld_id = 2'd2; ld_x = 6'd20;
        tick();
        ld = 1'b0;
        push_n(4'b0100, 2);
        repeat (5) tick();
        req = '0;
        check("t3_err", 32'(err), 32'h5);
        check("t3_x2",  xof(2),   32'd20);
        drain("t3_drain");

        // All four threads round-robin to completion.
        pulse_rst();
        for (int i = 0; i < NTHR; i++) begin
            ld = 1'b1; ld_id = 2'(i); ld_x = 6'd0;
            tick();
        end
        ld = 1'b0; req = 4'b1111;
        for (int r = 0; r < 20; r++) begin
            push_n(4'b0001, 1); push_n(4'b0010, 1);
            push_n(4'b0100, 1); push_n(4'b1000, 1);
        end
        repeat (85) tick();
        req = '0;
        check("t4_done", 32'(done),   32'hF);
        check("t4_err",  32'(err),    32'h0);
        check("t4_x",    32'(x_flat), 32'h492492);
        drain("t4_drain");

        // Corrupt PC of thread 3: frozen, never granted, ohfail raised.
        pulse_rst();
        tick();
        force dut.pc_q = 28'b0000011_0000001_0000001_0000001;
        req = 4'b1111;
        for (int r = 0; r < 3; r++) begin
            push_n(4'b0001, 1); push_n(4'b0010, 1); push_n(4'b0100, 1);
        end
        #1;
        release dut.pc_q;
        tick();
        check("t6_ohfail", 32'(ohfail), 32'd1);
        repeat (8) tick();
        req = '0;
        check("t6_x0", xof(0), 32'd4);
        check("t6_x1", xof(1), 32'd4);
        check("t6_x2", xof(2), 32'd4);
        check("t6_x3", xof(3), 32'd1);
        drain("t6_drain");
        ld = 1'b1; ld_id = 2'd3; ld_x = 6'd0;
        tick();
        ld = 1'b0;
        tick();
        check("t6_sticky", 32'(ohfail), 32'd1);
        pulse_rst();
        check("t6_rst_ohfail", 32'(ohfail), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
